// File: rtl/mem_arbiter.sv
// Purpose: shares one single-port sync data memory between the CPU data port and an external requester.
// Latency: grant/stall are combinational; read data returns one cycle after the issuing cycle for both sides.
// Backpressure: CPU is frozen via cpu_en while the external side is forced ahead; ext_req is held until ext_gnt.
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        cpu_en,
    input  logic [3:0]  cpu_mem_write_en,
    input  logic        cpu_mem_read_en,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_write_data,
    output logic [31:0] cpu_mem_read_data,
    input  logic        ext_req,
    input  logic [3:0]  ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    output logic [31:0] ext_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic [31:0] stall_count
);

    // Owner of the read issued in the previous cycle, used to steer mem_rdata.
    typedef enum logic [1:0] {
        OP_NONE   = 2'd0,
        OP_CPU_RD = 2'd1,
        OP_EXT_RD = 2'd2
    } last_op_e;

    last_op_e    last_op_q, last_op_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] cpu_hold_q, cpu_hold_d;
    logic [31:0] stall_count_q, stall_count_d;

    logic cpu_req;
    logic ext_win;
    logic cpu_stall;

    assign cpu_req   = en & ~rst & (cpu_mem_read_en | (|cpu_mem_write_en));
    assign ext_win   = ext_req & ~rst & (~cpu_req | (wait_cnt_q >= 4'(MAX_WAIT)));
    assign cpu_stall = cpu_req & ext_win;

    assign ext_gnt     = ext_win;
    assign cpu_en      = en & ~cpu_stall;
    assign stall_count = stall_count_q;

    // The returned word belongs to whoever issued last cycle's read; the CPU falls back to its held copy.
    assign ext_rvalid        = (last_op_q == OP_EXT_RD);
    assign ext_rdata         = mem_rdata;
    assign cpu_mem_read_data = (last_op_q == OP_CPU_RD) ? mem_rdata : cpu_hold_q;

    // Memory port mux: external side when it wins, else the CPU, else idle; a stalled CPU never reaches memory.
    always_comb begin
        mem_addr  = cpu_mem_addr;
        mem_wdata = cpu_mem_write_data;
        mem_we    = 4'h0;
        mem_re    = 1'b0;
        if (ext_win) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_we    = ext_we;
            mem_re    = (ext_we == 4'h0);
        end else if (cpu_req) begin
            mem_we = cpu_mem_write_en;
            mem_re = cpu_mem_read_en;
        end
    end

    // Next-state for read ownership, starvation counter, CPU hold register and stall counter.
    always_comb begin
        last_op_d     = OP_NONE;
        wait_cnt_d    = wait_cnt_q;
        cpu_hold_d    = cpu_hold_q;
        stall_count_d = stall_count_q;

        if (ext_win && (ext_we == 4'h0)) begin
            last_op_d = OP_EXT_RD;
        end else if (!ext_win && cpu_req && cpu_mem_read_en) begin
            last_op_d = OP_CPU_RD;
        end

        if (ext_win || !ext_req) begin
            wait_cnt_d = 4'h0;
        end else if (wait_cnt_q != 4'hF) begin
            wait_cnt_d = wait_cnt_q + 4'h1;
        end

        if (last_op_q == OP_CPU_RD) begin
            cpu_hold_d = mem_rdata;
        end

        if (cpu_stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'h1;
        end
    end

    // State registers; reset also drops any pending read return.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_op_q     <= OP_NONE;
            wait_cnt_q    <= 4'h0;
            cpu_hold_q    <= 32'h0;
            stall_count_q <= 32'h0;
        end else begin
            last_op_q     <= last_op_d;
            wait_cnt_q    <= wait_cnt_d;
            cpu_hold_q    <= cpu_hold_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter with a small byte-writable sync memory model.
// Latency: memory model returns read data one cycle after mem_re.
// Backpressure: none in the model; arbitration is exercised by directed vectors and sequences.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        en;
    logic        cpu_en;
    logic [3:0]  cpu_mem_write_en;
    logic        cpu_mem_read_en;
    logic [31:0] cpu_mem_addr;
    logic [31:0] cpu_mem_write_data;
    logic [31:0] cpu_mem_read_data;
    logic        ext_req;
    logic [3:0]  ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [31:0] ext_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic [31:0] stall_count;

    logic        bd_we;
    logic [31:0] bd_addr;
    logic [31:0] bd_data;

    int n_checks;
    int n_pass;

    mem_arbiter #(.MAX_WAIT(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .en                 (en),
        .cpu_en             (cpu_en),
        .cpu_mem_write_en   (cpu_mem_write_en),
        .cpu_mem_read_en    (cpu_mem_read_en),
        .cpu_mem_addr       (cpu_mem_addr),
        .cpu_mem_write_data (cpu_mem_write_data),
        .cpu_mem_read_data  (cpu_mem_read_data),
        .ext_req            (ext_req),
        .ext_we             (ext_we),
        .ext_addr           (ext_addr),
        .ext_wdata          (ext_wdata),
        .ext_gnt            (ext_gnt),
        .ext_rvalid         (ext_rvalid),
        .ext_rdata          (ext_rdata),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_we             (mem_we),
        .mem_re             (mem_re),
        .mem_rdata          (mem_rdata),
        .stall_count        (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: backdoor preload port, byte-enable writes, one-cycle read latency.
    logic [31:0] tb_mem [0:255];
    always @(posedge clk) begin
        if (bd_we) begin
            tb_mem[bd_addr[9:2]] <= bd_data;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) tb_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (mem_re) mem_rdata <= tb_mem[mem_addr[9:2]];
    end

    typedef struct {
        logic        en;
        logic        cpu_re;
        logic [3:0]  cpu_we;
        logic        ext_req;
        logic [3:0]  ext_we;
        logic        exp_gnt;
        logic        exp_cpu_en;
        logic        exp_re;
        logic [3:0]  exp_we;
        logic        chk_addr;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en                 = 1'b1;
        cpu_mem_read_en    = 1'b0;
        cpu_mem_write_en   = 4'h0;
        cpu_mem_addr       = 32'h0;
        cpu_mem_write_data = 32'h0;
        ext_req            = 1'b0;
        ext_we             = 4'h0;
        ext_addr           = 32'h0;
        ext_wdata          = 32'h0;
    endtask

    task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        tick();
        bd_we   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        bd_we    = 1'b0;
        bd_addr  = 32'h0;
        bd_data  = 32'h0;
        idle_inputs();

        //                  en    cre   cwe    ereq  ewe    gnt   cen   re    we     chk   addr
        vecs[0] = '{1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 32'h100};
        vecs[1] = '{1'b1, 1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 32'h100};
        vecs[2] = '{1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 32'h40};
        vecs[3] = '{1'b1, 1'b0, 4'h0, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 32'h40};
        vecs[4] = '{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 32'h100};
        vecs[5] = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 32'h40};
        vecs[6] = '{1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 4'h5, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 4'h5, 1'b1, 32'h100};
        vecs[9] = '{1'b1, 1'b1, 4'h0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 32'h100};

        // Reset with both sides requesting: nothing may reach memory.
        rst             = 1'b1;
        cpu_mem_read_en = 1'b1;
        ext_req         = 1'b1;
        tick();
        check("rst_gnt",     32'(ext_gnt), 32'h0);
        check("rst_mem_re",  32'(mem_re), 32'h0);
        check("rst_mem_we",  32'(mem_we), 32'h0);
        check("rst_cpu_en",  32'(cpu_en), 32'h1);
        check("rst_rvalid",  32'(ext_rvalid), 32'h0);
        check("rst_stall",   stall_count, 32'h0);
        check("rst_cpu_rd",  cpu_mem_read_data, 32'h0);
        tick();
        rst = 1'b0;
        idle_inputs();
        tick();

        // Table vectors, each followed by an idle cycle so the wait counter restarts at zero.
        for (int i = 0; i < 10; i++) begin
            en               = vecs[i].en;
            cpu_mem_read_en  = vecs[i].cpu_re;
            cpu_mem_write_en = vecs[i].cpu_we;
            cpu_mem_addr     = 32'h100;
            ext_req          = vecs[i].ext_req;
            ext_we           = vecs[i].ext_we;
            ext_addr         = 32'h40;
            ext_wdata        = 32'h0F0F0F0F;
            #1;
            check($sformatf("vec%0d_gnt", i),    32'(ext_gnt), 32'(vecs[i].exp_gnt));
            check($sformatf("vec%0d_cpu_en", i), 32'(cpu_en),  32'(vecs[i].exp_cpu_en));
            check($sformatf("vec%0d_mem_re", i), 32'(mem_re),  32'(vecs[i].exp_re));
            check($sformatf("vec%0d_mem_we", i), 32'(mem_we),  32'(vecs[i].exp_we));
            if (vecs[i].chk_addr) check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
            tick();
            idle_inputs();
            tick();
        end

        // CPU-only load.
        bd_write(32'h100, 32'hDEADBEEF);
        cpu_mem_read_en = 1'b1;
        cpu_mem_addr    = 32'h100;
        #1;
        check("cpuonly_re",     32'(mem_re), 32'h1);
        check("cpuonly_cpu_en", 32'(cpu_en), 32'h1);
        check("cpuonly_addr",   mem_addr, 32'h100);
        tick();
        cpu_mem_read_en = 1'b0;
        #1;
        check("cpuonly_rdata",  cpu_mem_read_data, 32'hDEADBEEF);
        check("cpuonly_cpu_en2", 32'(cpu_en), 32'h1);
        check("cpuonly_stall",  stall_count, 32'h0);
        tick();

        // External-only write then read.
        ext_req   = 1'b1;
        ext_we    = 4'hF;
        ext_addr  = 32'h40;
        ext_wdata = 32'h12345678;
        #1;
        check("extonly_wgnt", 32'(ext_gnt), 32'h1);
        check("extonly_we",   32'(mem_we), 32'hF);
        tick();
        ext_we = 4'h0;
        #1;
        check("extonly_rgnt", 32'(ext_gnt), 32'h1);
        check("extonly_re",   32'(mem_re), 32'h1);
        tick();
        ext_req = 1'b0;
        #1;
        check("extonly_rvalid", 32'(ext_rvalid), 32'h1);
        check("extonly_rdata",  ext_rdata, 32'h12345678);
        tick();
        check("extonly_rvalid_off", 32'(ext_rvalid), 32'h0);

        // Starvation: forced grant on the 5th contended cycle, CPU wins the 6th.
        cpu_mem_read_en = 1'b1;
        cpu_mem_addr    = 32'h100;
        ext_req         = 1'b1;
        ext_we          = 4'h0;
        ext_addr        = 32'h40;
        for (int c = 1; c <= 6; c++) begin
            #1;
            check($sformatf("starve_c%0d_gnt", c),    32'(ext_gnt), (c == 5) ? 32'h1 : 32'h0);
            check($sformatf("starve_c%0d_cpu_en", c), 32'(cpu_en),  (c == 5) ? 32'h0 : 32'h1);
            if (c == 6) check("starve_stall_count", stall_count, 32'h1);
            tick();
        end
        idle_inputs();
        tick();

        // Stall right after a CPU read: the held word must survive the external return.
        bd_write(32'h300, 32'hAAAA5555);
        bd_write(32'h44,  32'h11110000);
        ext_req         = 1'b1;
        ext_we          = 4'h0;
        ext_addr        = 32'h44;
        cpu_mem_read_en = 1'b1;
        cpu_mem_addr    = 32'h100;
        tick(); tick(); tick();
        cpu_mem_addr = 32'h300;
        #1;
        check("hold_t_gnt",  32'(ext_gnt), 32'h0);
        check("hold_t_addr", mem_addr, 32'h300);
        tick();
        cpu_mem_addr = 32'h100;
        #1;
        check("hold_t1_gnt",    32'(ext_gnt), 32'h1);
        check("hold_t1_cpu_en", 32'(cpu_en), 32'h0);
        check("hold_t1_rdata",  cpu_mem_read_data, 32'hAAAA5555);
        tick();
        ext_req = 1'b0;
        #1;
        check("hold_t2_rdata",  cpu_mem_read_data, 32'hAAAA5555);
        check("hold_t2_rvalid", 32'(ext_rvalid), 32'h1);
        check("hold_t2_erdata", ext_rdata, 32'h11110000);
        check("hold_t2_cpu_en", 32'(cpu_en), 32'h1);
        tick();
        idle_inputs();
        tick();

        // Stalled store is suppressed, then issued once on the retry.
        ext_req         = 1'b1;
        ext_we          = 4'h0;
        ext_addr        = 32'h40;
        cpu_mem_read_en = 1'b1;
        cpu_mem_addr    = 32'h100;
        tick(); tick(); tick(); tick();
        cpu_mem_read_en    = 1'b0;
        cpu_mem_write_en   = 4'hF;
        cpu_mem_addr       = 32'h200;
        cpu_mem_write_data = 32'hCAFEF00D;
        #1;
        check("sw_stall_gnt",    32'(ext_gnt), 32'h1);
        check("sw_stall_cpu_en", 32'(cpu_en), 32'h0);
        check("sw_stall_we",     32'(mem_we), 32'h0);
        tick();
        ext_req = 1'b0;
        #1;
        check("sw_retry_we",    32'(mem_we), 32'hF);
        check("sw_retry_addr",  mem_addr, 32'h200);
        check("sw_retry_wdata", mem_wdata, 32'hCAFEF00D);
        tick();
        idle_inputs();
        ext_req  = 1'b1;
        ext_addr = 32'h200;
        #1;
        check("sw_readback_gnt", 32'(ext_gnt), 32'h1);
        tick();
        ext_req = 1'b0;
        #1;
        check("sw_readback_data", ext_rdata, 32'hCAFEF00D);
        check("sw_stall_count",   stall_count, 32'h3);
        tick();

        // Reset right after an external read grant with the wait counter at 3.
        ext_req         = 1'b1;
        ext_we          = 4'h0;
        ext_addr        = 32'h40;
        cpu_mem_read_en = 1'b1;
        cpu_mem_addr    = 32'h100;
        tick(); tick(); tick();
        cpu_mem_read_en = 1'b0;
        #1;
        check("rstmid_pre_wait", 32'(dut.wait_cnt_q), 32'h3);
        check("rstmid_pre_gnt",  32'(ext_gnt), 32'h1);
        tick();
        rst             = 1'b1;
        cpu_mem_read_en = 1'b1;
        #1;
        check("rstmid_gnt",    32'(ext_gnt), 32'h0);
        check("rstmid_mem_re", 32'(mem_re), 32'h0);
        check("rstmid_cpu_en", 32'(cpu_en), 32'h1);
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        check("rstmid_rvalid", 32'(ext_rvalid), 32'h0);
        check("rstmid_wait",   32'(dut.wait_cnt_q), 32'h0);
        check("rstmid_stall",  stall_count, 32'h0);
        check("rstmid_cpu_rd", cpu_mem_read_data, 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port synchronous data memory between the MIPS CPU data port (EX-stage request, MEM-stage read return) and an external requester such as a DMA engine or accelerator. The CPU has priority. A starvation counter forces an external grant after a bounded wait, and the CPU is stalled through its `en` input while it waits. A CPU-owned read-data holding register keeps MEM-stage data correct across stall cycles.

## Interface
- `MAX_WAIT`, default 4: number of consecutive denied external-request cycles before the external requester is forced ahead of the CPU. Legal range 0..15; 0 means the external requester always wins.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `en` input 1: system enable. CPU requests are considered only when `en`=1.
- `cpu_en` output 1: enable to the CPU; equals `en & ~cpu_stall`.
- `cpu_mem_write_en` input 4: CPU byte write enables.
- `cpu_mem_read_en` input 1: CPU read request.
- `cpu_mem_addr` input 32: CPU byte address.
- `cpu_mem_write_data` input 32: CPU write data.
- `cpu_mem_read_data` output 32: read data returned to the CPU MEM stage.
- `ext_req` input 1: external request, held until granted.
- `ext_we` input 4: external byte write enables; 0 means read.
- `ext_addr` input 32: external address.
- `ext_wdata` input 32: external write data.
- `ext_gnt` output 1: combinational; request accepted this cycle.
- `ext_rvalid` output 1: registered; `ext_rdata` valid this cycle.
- `ext_rdata` output 32: external read data.
- `mem_addr` output 32: memory address.
- `mem_wdata` output 32: memory write data.
- `mem_we` output 4: memory byte write enables.
- `mem_re` output 1: memory read enable.
- `mem_rdata` input 32: memory read data, valid the cycle after `mem_re`.
- `stall_count` output 32: saturating count of CPU stall cycles.

## Operation
- `cpu_req` = `en & ~rst & (cpu_mem_read_en | |cpu_mem_write_en)`.
- `ext_win` = `ext_req & ~rst & (~cpu_req | wait_cnt >= MAX_WAIT)`.
- `cpu_stall` = `cpu_req & ext_win`.
- `ext_gnt` = `ext_win`.
- Memory is driven from the external port when `ext_win`=1. Otherwise it is driven from the CPU when `cpu_req`=1.
- When neither side is granted: `mem_we`=0 and `mem_re`=0. `mem_addr` and `mem_wdata` are don't-care.
- A stalled CPU access is never forwarded to memory. Its write enables are suppressed, and the CPU re-presents the same access next cycle because its pipeline is frozen.
- `wait_cnt` (4 bits):
  - cleared on `ext_gnt` or when `ext_req`=0;
  - otherwise increments each cycle `ext_req`=1, saturating at 15.
- Owner register `last_op` captures one of {NONE, CPU_RD, EXT_RD} each cycle: the read issued this cycle and its owner.
- Next cycle, when `last_op`=EXT_RD: `ext_rvalid`=1 and `ext_rdata`=`mem_rdata`.
- Holding register `cpu_hold` loads `mem_rdata` on every cycle with `last_op`=CPU_RD.
- `cpu_mem_read_data` = `mem_rdata` when `last_op`=CPU_RD, else `cpu_hold`. This keeps the MEM-stage load correct when the CPU stalled on the cycle after its read.
- `stall_count` increments on each `cpu_stall` cycle and saturates at 0xFFFFFFFF.

## Timing
- Grant and stall are combinational, same cycle as the request. Memory read latency is 1 cycle for both sides.
- External writes complete in the grant cycle. External reads return with `ext_rvalid` exactly one cycle after `ext_gnt`.
- Back-to-back external grants are legal; `ext_rvalid` may then be high on consecutive cycles.
- Simultaneous requests with `wait_cnt` < `MAX_WAIT`:
  - CPU is granted and `cpu_en` = `en`;
  - external side waits and `wait_cnt` increments.
- Simultaneous requests with `wait_cnt` >= `MAX_WAIT`:
  - external side is granted and `cpu_en`=0 for that cycle;
  - next cycle `wait_cnt`=0, so the CPU wins if `ext_req` is still asserted.
  - Worst case is therefore at most 1 stall cycle per `MAX_WAIT`+1 contended cycles.
- With `en`=0, the CPU is ignored and the external requester is granted on every request.
- Reset applies on a clock edge while `rst`=1 and sets:
  - `wait_cnt`=0;
  - `last_op`=NONE;
  - `cpu_hold`=0;
  - `stall_count`=0.
- While `rst`=1: `ext_gnt`=0, `mem_we`=0, `mem_re`=0, `ext_rvalid`=0 (after the first edge), and `cpu_en`=`en`.
- Reset asserted mid-read discards the pending return: no `ext_rvalid` is produced after reset.

## Test plan
- CPU-only traffic:
  - stimulus: CPU `lw` at 0x100 (mem holds 0xDEADBEEF), `en`=1, no `ext_req`;
  - response: `mem_re`=1 in EX cycle; `cpu_mem_read_data`=0xDEADBEEF next cycle; `cpu_en` never low; `stall_count`=0.
- External-only traffic:
  - stimulus: `ext_req` write 0x12345678 to 0x40 (`ext_we`=0xF), then read 0x40;
  - response: `ext_gnt`=1 each cycle; `ext_rvalid`=1 with `ext_rdata`=0x12345678 one cycle after the read grant.
- Starvation, `MAX_WAIT`=4:
  - stimulus: CPU requests every cycle and `ext_req` is held;
  - response: `ext_gnt` first asserts on the 5th cycle with `cpu_en`=0 that cycle only; `stall_count`=1; the CPU wins the following cycle.
- Stall after CPU read:
  - stimulus: CPU read of 0xAAAA5555 at cycle t; forced external read of 0x11110000 at t+1;
  - response: `cpu_mem_read_data`=0xAAAA5555 at both t+1 and t+2; `ext_rdata`=0x11110000 at t+2.
- Stalled write suppression:
  - stimulus: CPU `sw` 0xCAFEF00D contends with a forced external read;
  - response: `mem_we`=0 in the stall cycle; the write is issued exactly once, in the next cycle.
- Reset mid-operation:
  - stimulus: `rst` asserted in the cycle after an external read grant, with `wait_cnt`=3;
  - response: no `ext_rvalid` after the edge; `wait_cnt`=0, `stall_count`=0, `cpu_mem_read_data`=0.
